serial_msb_comparator: RTL and testbench

- Sequential magnitude comparator. It compares two WIDTH-bit unsigned words one bit per clock, scanning from the MSB down.
- It is the other direction of the combinational LSB-to-MSB ripple comparator cell chain. The G/L decision state is held in registers instead of rippling through cascaded cells.
- Sits between a word source with a start strobe and a consumer that samples the result on a done pulse.

---
 rtl/serial_msb_comparator.sv | 160 ++++++++++++++++
 tb/tb_serial_msb_comparator.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_msb_comparator.sv
// rtl/serial_msb_comparator.sv - bit-serial MSB-first unsigned magnitude comparator
//
// Compares two WIDTH-bit unsigned words one bit per clock, starting at the MSB.
// The greater/less decision is held in registers instead of rippling through
// a chain of cells.
//
// Optional build macro: FIXED_LATENCY_EN
//   undefined (default) : leave the scan at the first differing bit (early exit)
//   defined             : always scan WIDTH bits; the first differing bit decides
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous active-high reset
//   start     - compare request, sampled only in IDLE
//   x, y      - operands, captured on an accepted start
//   busy      - high while scanning (SHIFT)
//   done      - one-cycle pulse when the result is valid
//   gt/lt/eq  - result flags, exactly one set after any done
//   bits_used - number of bit positions examined for the last result

module serial_msb_comparator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic [CNT_W-1:0] bits_used
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           state;
    logic [WIDTH-1:0] sx;
    logic [WIDTH-1:0] sy;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pos;
    logic             msb_x;
    logic             msb_y;

    // cnt counts down from WIDTH, so the 1-based bit position under test
    // (counted from the MSB) is WIDTH - cnt + 1.
    assign pos   = WIDTH_C - cnt + ONE_C;
    assign msb_x = sx[WIDTH-1];
    assign msb_y = sy[WIDTH-1];

`ifdef FIXED_LATENCY_EN
    // Sticky: once a differing bit has set gt/lt, later bits are ignored.
    logic decided;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sx        <= '0;
            sy        <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            bits_used <= '0;
`ifdef FIXED_LATENCY_EN
            decided   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sx    <= x;
                        sy    <= y;
                        cnt   <= WIDTH_C;
                        gt    <= 1'b0;
                        lt    <= 1'b0;
                        eq    <= 1'b0;
                        busy  <= 1'b1;
                        state <= SHIFT;
`ifdef FIXED_LATENCY_EN
                        decided <= 1'b0;
`endif
                    end
                end

                SHIFT: begin
`ifdef FIXED_LATENCY_EN
                    if (!decided && (msb_x != msb_y)) begin
                        gt        <= msb_x;
                        lt        <= msb_y;
                        bits_used <= pos;
                        decided   <= 1'b1;
                    end
                    if (cnt == ONE_C) begin
                        // Last bit: equal only if nothing differed anywhere.
                        if (!decided && (msb_x == msb_y)) begin
                            eq        <= 1'b1;
                            bits_used <= WIDTH_C;
                        end
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        sx  <= {sx[WIDTH-2:0], 1'b0};
                        sy  <= {sy[WIDTH-2:0], 1'b0};
                        cnt <= cnt - ONE_C;
                    end
`else
                    if (msb_x && !msb_y) begin
                        gt        <= 1'b1;
                        bits_used <= pos;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else if (!msb_x && msb_y) begin
                        lt        <= 1'b1;
                        bits_used <= pos;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else if (cnt == ONE_C) begin
                        eq        <= 1'b1;
                        bits_used <= WIDTH_C;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        sx  <= {sx[WIDTH-2:0], 1'b0};
                        sy  <= {sy[WIDTH-2:0], 1'b0};
                        cnt <= cnt - ONE_C;
                    end
`endif
                end

                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_msb_comparator.sv
// tb/tb_serial_msb_comparator.sv - directed self-checking bench for serial_msb_comparator

module tb_serial_msb_comparator;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic             gt;
    logic             lt;
    logic             eq;
    logic [CNT_W-1:0] bits_used;

    int vectors;
    int miscompares;

    serial_msb_comparator #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .x         (x),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .gt        (gt),
        .lt        (lt),
        .eq        (eq),
        .bits_used (bits_used)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected start-to-done latency when the first differing bit is k (1-based from MSB).
    function automatic int exp_lat(input int k);
`ifdef FIXED_LATENCY_EN
        return WIDTH + 1;
`else
        return k + 1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one start pulse and returns the cycles from acceptance to done (0 = timeout).
    task automatic run_compare(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                               output int lat);
        x     = xv;
        y     = yv;
        start = 1'b1;
        tick();
        start = 1'b0;
        x     = ~xv;
        y     = ~yv;
        lat   = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int ndone;
        reset = 1'b1;
        start = 1'b1;
        x     = 8'hFF;
        y     = 8'h00;
        repeat (3) tick();
        vectors++;
        if ({busy, done, gt, lt, eq} !== 5'b0 || bits_used !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b gt=%b lt=%b eq=%b bits=%0d, want all 0",
                     busy, done, gt, lt, eq, bits_used);
        end
        start = 1'b0;
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) ndone++;
        end
        vectors++;
        if (ndone !== 0) begin
            miscompares++;
            $display("FAIL reset_idle_done: got %0d done pulses, want 0", ndone);
        end
    endtask

    task automatic test_msb_decides();
        int lat;
        x     = 8'h80;
        y     = 8'h7F;
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL msb_busy: got %b, want 1", busy);
        end
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        vectors++;
        if (lat !== exp_lat(1)) begin
            miscompares++;
            $display("FAIL msb_latency: got %0d, want %0d", lat, exp_lat(1));
        end
        vectors++;
        if ({gt, lt, eq} !== 3'b100 || bits_used !== CNT_W'(1) || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL msb_result: got gt/lt/eq=%b%b%b bits=%0d busy=%b, want 100 bits=1 busy=0",
                     gt, lt, eq, bits_used, busy);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || {gt, lt, eq} !== 3'b100) begin
            miscompares++;
            $display("FAIL msb_done_pulse: got done=%b gt/lt/eq=%b%b%b, want done=0 100",
                     done, gt, lt, eq);
        end
    endtask

    task automatic test_lsb_decides();
        int lat;
        run_compare(8'h54, 8'h55, lat);
        vectors++;
        if (lat !== exp_lat(8)) begin
            miscompares++;
            $display("FAIL lsb_latency: got %0d, want %0d", lat, exp_lat(8));
        end
        vectors++;
        if ({gt, lt, eq} !== 3'b010 || bits_used !== CNT_W'(8)) begin
            miscompares++;
            $display("FAIL lsb_result: got gt/lt/eq=%b%b%b bits=%0d, want 010 bits=8",
                     gt, lt, eq, bits_used);
        end
        tick();
    endtask

    task automatic test_equal();
        int lat;
        logic [WIDTH-1:0] vals [2];
        vals[0] = 8'hA5;
        vals[1] = 8'h00;
        for (int n = 0; n < 2; n++) begin
            run_compare(vals[n], vals[n], lat);
            vectors++;
            if (lat !== WIDTH + 1) begin
                miscompares++;
                $display("FAIL equal_latency[%0h]: got %0d, want %0d", vals[n], lat, WIDTH + 1);
            end
            vectors++;
            if ({gt, lt, eq} !== 3'b001 || bits_used !== CNT_W'(8)) begin
                miscompares++;
                $display("FAIL equal_result[%0h]: got gt/lt/eq=%b%b%b bits=%0d, want 001 bits=8",
                         vals[n], gt, lt, eq, bits_used);
            end
            tick();
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        int ndone;
        logic [2:0] res;
        logic [CNT_W-1:0] bu;
        x     = 8'h0F;
        y     = 8'h10;
        start = 1'b1;
        tick();
        x     = 8'hFF;
        y     = 8'h00;
        tick();
        start = 1'b0;
        ndone = 0;
        lat   = 0;
        res   = 3'b000;
        bu    = '0;
        for (int i = 2; i <= 30; i++) begin
            tick();
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    lat = i;
                    res = {gt, lt, eq};
                    bu  = bits_used;
                end
            end
        end
        vectors++;
        if (ndone !== 1 || lat !== exp_lat(4)) begin
            miscompares++;
            $display("FAIL ignore_done: got %0d pulses latency %0d, want 1 pulse latency %0d",
                     ndone, lat, exp_lat(4));
        end
        vectors++;
        if (res !== 3'b010 || bu !== CNT_W'(4)) begin
            miscompares++;
            $display("FAIL ignore_result: got gt/lt/eq=%b bits=%0d, want 010 bits=4", res, bu);
        end
        run_compare(8'hFF, 8'h00, lat);
        vectors++;
        if (lat !== exp_lat(1) || {gt, lt, eq} !== 3'b100 || bits_used !== CNT_W'(1)) begin
            miscompares++;
            $display("FAIL ignore_restart: got lat=%0d gt/lt/eq=%b%b%b bits=%0d, want lat=%0d 100 bits=1",
                     lat, gt, lt, eq, bits_used, exp_lat(1));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        x     = 8'h80;
        y     = 8'h7F;
        start = 1'b1;
        t1    = 0;
        t2    = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                if (t1 == 0) t1 = i;
                else begin
                    t2 = i;
                    break;
                end
            end
        end
        start = 1'b0;
        vectors++;
        if (t1 == 0 || t2 == 0 || (t2 - t1) !== exp_lat(1) + 1) begin
            miscompares++;
            $display("FAIL back_to_back_period: got dones at %0d and %0d, want spacing %0d",
                     t1, t2, exp_lat(1) + 1);
        end
        repeat (15) tick();
    endtask

    task automatic test_reset_mid_op();
        int ndone;
        int lat;
        x     = 8'h01;
        y     = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        vectors++;
        if ({busy, done, gt, lt, eq} !== 5'b0 || bits_used !== '0) begin
            miscompares++;
            $display("FAIL abort_outputs: got busy=%b done=%b gt=%b lt=%b eq=%b bits=%0d, want all 0",
                     busy, done, gt, lt, eq, bits_used);
        end
        tick();
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) ndone++;
        end
        vectors++;
        if (ndone !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d done pulses, want 0", ndone);
        end
        run_compare(8'h01, 8'h00, lat);
        vectors++;
        if (lat !== exp_lat(8) || {gt, lt, eq} !== 3'b100 || bits_used !== CNT_W'(8)) begin
            miscompares++;
            $display("FAIL abort_recompare: got lat=%0d gt/lt/eq=%b%b%b bits=%0d, want lat=%0d 100 bits=8",
                     lat, gt, lt, eq, bits_used, exp_lat(8));
        end
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start       = 1'b0;
        x           = '0;
        y           = '0;
        test_reset();
        test_msb_decides();
        test_lsb_decides();
        test_equal();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
